// File: rtl/ext_queue.sv
// Immediate-extension unit with a small result FIFO: each accepted imm/EXTop pair
// is extended combinationally and buffered; the oldest result is presented at the output.
module ext_queue #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          imm,
    input  logic [2:0]               EXTop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         EXTout,
    output logic                     op_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [OUT_W-1:0] r_data [DEPTH];
    logic             r_err  [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic [OUT_W-1:0] w_ext;
    logic             w_err;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_ext = '0;
        w_err = 1'b0;
        case (EXTop)
            3'd0:    w_ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            3'd1:    w_ext = {{(OUT_W-IN_W){1'b0}}, imm};
            3'd2:    w_ext = {imm, {(OUT_W-IN_W){1'b0}}};
            3'd3:    w_ext = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            3'd4:    w_ext = {{(OUT_W-8){1'b0}}, imm[7:0]};
            3'd5:    w_ext = {{(OUT_W-16){imm[15]}}, imm[15:0]};
            3'd6:    w_ext = {{(OUT_W-16){1'b0}}, imm[15:0]};
            default: begin
                w_ext = {{(OUT_W-IN_W){1'b0}}, imm};
                w_err = 1'b1;
            end
        endcase
    end

    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    assign in_ready  = !flush && ((r_count < FULL) || w_pop);
    assign w_push    = in_valid && in_ready;

    assign EXTout = out_valid ? r_data[r_rptr] : '0;
    assign op_err = out_valid ? r_err[r_rptr]  : 1'b0;
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are never visible while count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= w_ext;
            r_err[r_wptr]  <= w_err;
        end
    end

endmodule

// File: tb/tb_ext_queue.sv
// Scoreboard bench for ext_queue: stimulus pushes expected results, a monitor pops
// and compares them on every output handshake; a 64-bit instance covers wide high mode.
module tb_ext_queue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] imm;
    logic [2:0]  EXTop;
    logic        in_ready, out_valid, op_err;
    logic [31:0] EXTout;
    logic [1:0]  count;

    logic        in_valid2, out_ready2;
    logic [15:0] imm2;
    logic [2:0]  EXTop2;
    logic        in_ready2, out_valid2, op_err2;
    logic [63:0] EXTout2;
    logic [1:0]  count2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] sb[$];
    logic [32:0] pend;

    always #5 clk = ~clk;

    ext_queue #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .EXTop(EXTop), .out_valid(out_valid), .out_ready(out_ready),
        .EXTout(EXTout), .op_err(op_err), .count(count)
    );

    ext_queue #(.IN_W(16), .OUT_W(64), .DEPTH(2)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
        .imm(imm2), .EXTop(EXTop2), .out_valid(out_valid2), .out_ready(out_ready2),
        .EXTout(EXTout2), .op_err(op_err2), .count(count2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", {op_err, EXTout});
                end else begin
                    chk("scoreboard", {31'b0, op_err, EXTout}, {31'b0, sb.pop_front()});
                end
            end
        end
    end

    // Set inputs at posedge+1; settle so combinational outputs can be checked.
    task automatic drive(input logic v, input logic [15:0] im, input logic [2:0] op,
                         input logic rdy, input logic [32:0] exp);
        in_valid  = v;
        imm       = im;
        EXTop     = op;
        out_ready = rdy;
        pend      = exp;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        if (!reset || flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    logic [32:0] mode_exp [8];

    initial begin
        mode_exp[0] = {1'b0, 32'hFFFF8001};
        mode_exp[1] = {1'b0, 32'h00008001};
        mode_exp[2] = {1'b0, 32'h80010000};
        mode_exp[3] = {1'b0, 32'h00000001};
        mode_exp[4] = {1'b0, 32'h00000001};
        mode_exp[5] = {1'b0, 32'hFFFF8001};
        mode_exp[6] = {1'b0, 32'h00008001};
        mode_exp[7] = {1'b1, 32'h00008001};

        reset = 1'b0; flush = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; imm2 = '0; EXTop2 = '0;
        drive(1'b0, 16'h0, 3'd0, 1'b0, '0);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_EXTout", {32'b0, EXTout}, 64'd0);
        chk("reset_op_err", {63'b0, op_err}, 64'd0);
        chk("reset_count", {62'b0, count}, 64'd0);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);

        // Wide instance: high mode and sign-extend at OUT_W=64
        in_valid2 = 1'b1; imm2 = 16'hFFFF; EXTop2 = 3'd2; out_ready2 = 1'b0;
        step();
        chk("w64_high", EXTout2, 64'hFFFF000000000000);
        chk("w64_count", {62'b0, count2}, 64'd1);
        imm2 = 16'h8001; EXTop2 = 3'd0; out_ready2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        #1;
        chk("w64_sext", EXTout2, 64'hFFFFFFFFFFFF8001);
        step();
        out_ready2 = 1'b0;

        // All extension modes back to back, consumer always ready
        for (int unsigned i = 0; i < 8; i++) begin
            drive(1'b1, 16'h8001, 3'(i), 1'b1, mode_exp[i]);
            step();
        end
        drive(1'b1, 16'h0080, 3'd3, 1'b1, {1'b0, 32'hFFFFFF80});
        step();
        drive(1'b1, 16'h0080, 3'd4, 1'b1, {1'b0, 32'h00000080});
        step();
        drive(1'b0, 16'h0, 3'd0, 1'b1, '0);
        step();
        step();
        chk("drain_count", {62'b0, count}, 64'd0);

        // Fill and backpressure
        drive(1'b1, 16'h00A1, 3'd1, 1'b0, {1'b0, 32'h000000A1});
        chk("fill_rdy0", {63'b0, in_ready}, 64'd1);
        step();
        drive(1'b1, 16'h00B2, 3'd1, 1'b0, {1'b0, 32'h000000B2});
        chk("fill_count1", {62'b0, count}, 64'd1);
        chk("fill_rdy1", {63'b0, in_ready}, 64'd1);
        step();
        drive(1'b1, 16'h00C3, 3'd1, 1'b0, {1'b0, 32'h000000C3});
        chk("fill_count2", {62'b0, count}, 64'd2);
        chk("fill_full_rdy", {63'b0, in_ready}, 64'd0);
        chk("fill_head", {32'b0, EXTout}, 64'h000000A1);
        step();
        chk("hold_head", {32'b0, EXTout}, 64'h000000A1);
        chk("hold_count", {62'b0, count}, 64'd2);
        drive(1'b1, 16'h00C3, 3'd1, 1'b1, {1'b0, 32'h000000C3});
        chk("pop_frees_rdy", {63'b0, in_ready}, 64'd1);
        step();
        chk("after_swap_count", {62'b0, count}, 64'd2);

        // Sustained push+pop at full occupancy across several pointer wraps
        for (int unsigned i = 0; i < 8; i++) begin
            drive(1'b1, 16'hF000 | 16'(i), 3'd0, 1'b1, {1'b0, 32'hFFFFF000 | i});
            chk("full_stream_rdy", {63'b0, in_ready}, 64'd1);
            step();
            chk("full_stream_count", {62'b0, count}, 64'd2);
        end
        drive(1'b0, 16'h0, 3'd0, 1'b1, '0);
        step();
        step();
        chk("drain2_count", {62'b0, count}, 64'd0);
        chk("drain2_sb", 64'(sb.size()), 64'd0);

        // Flush with full buffer and a push offered
        drive(1'b1, 16'h0011, 3'd1, 1'b0, {1'b0, 32'h00000011});
        step();
        drive(1'b1, 16'h0022, 3'd1, 1'b0, {1'b0, 32'h00000022});
        step();
        flush = 1'b1;
        drive(1'b1, 16'h0033, 3'd1, 1'b0, {1'b0, 32'h00000033});
        chk("flush_rdy", {63'b0, in_ready}, 64'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0, '0);
        chk("flush_count", {62'b0, count}, 64'd0);
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_EXTout", {32'b0, EXTout}, 64'd0);
        drive(1'b1, 16'h0044, 3'd7, 1'b1, {1'b1, 32'h00000044});
        step();
        drive(1'b0, 16'h0, 3'd0, 1'b1, '0);
        step();

        // Reset mid-stream with one entry and a push offered
        drive(1'b1, 16'h0055, 3'd1, 1'b0, {1'b0, 32'h00000055});
        step();
        reset = 1'b0;
        drive(1'b1, 16'h0066, 3'd1, 1'b0, {1'b0, 32'h00000066});
        step();
        reset = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 1'b1, '0);
        chk("rst_mid_count", {62'b0, count}, 64'd0);
        chk("rst_mid_EXTout", {32'b0, EXTout}, 64'd0);
        chk("rst_mid_rdy", {63'b0, in_ready}, 64'd1);
        chk("rst_mid_valid", {63'b0, out_valid}, 64'd0);
        step();
        step();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ext_queue.md
EXT_QUEUE -- requirements
Module: ext_queue

Interface
REQ-001 SHALL have parameter IN_W, default 16, input immediate width (>= 16).
REQ-002 SHALL have parameter OUT_W, default 32, extended result width (> IN_W).
REQ-003 SHALL have parameter DEPTH, default 2, result buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port flush  in  1  discard all buffered results.
REQ-007 SHALL have port in_valid  in  1  imm/EXTop present.
REQ-008 SHALL have port in_ready  out  1  buffer can accept this cycle.
REQ-009 SHALL have port imm  in  IN_W  raw immediate.
REQ-010 SHALL have port EXTop  in  3  extension mode.
REQ-011 SHALL have port out_valid  out  1  EXTout holds a valid result.
REQ-012 SHALL have port out_ready  in  1  consumer takes result this cycle.
REQ-013 SHALL have port EXTout  out  OUT_W  oldest buffered result.
REQ-014 SHALL have port op_err  out  1  oldest result came from reserved EXTop.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL compute per EXTop: 0 sign-extend imm; 1 zero-extend imm; 2 high: imm in top IN_W bits, low OUT_W-IN_W bits zero; 3 sign-extend imm[7:0]; 4 zero-extend imm[7:0]; 5 sign-extend imm[15:0]; 6 zero-extend imm[15:0]; 7 reserved: zero-extend imm, op_err=1 stored with entry.
REQ-017 SHALL accept on in_valid && in_ready; result computed combinationally and written into buffer at that edge.
REQ-018 SHALL deliver on out_valid && out_ready; entry popped at that edge.
REQ-019 SHALL give 1-cycle latency: accept at edge N -> out_valid=1 with that result after edge N when buffer was empty; no combinational in->out path.
REQ-020 SHALL assert in_ready = (count < DEPTH) || (out_valid && out_ready) (pop frees a slot same cycle).
REQ-021 SHALL assert out_valid = (count != 0); EXTout/op_err driven from head entry, 0 when empty.
REQ-022 SHALL preserve FIFO order; read/write pointers wrap modulo DEPTH.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged, including when full and when count=1 (head replaced by new entry next cycle).
REQ-024 SHALL hold EXTout, op_err stable while out_valid && !out_ready.
REQ-025 SHALL, on flush, set count=0 and pointers=0 at the edge; a push in the same cycle is dropped; a pop in the same cycle has no additional effect.
REQ-026 SHALL assert in_ready=0 during a flush cycle.
REQ-027 SHALL keep count in range 0..DEPTH; no overflow on push-when-full (in_ready=0 prevents it).

Reset
REQ-028 SHALL, when reset=0 at a rising edge, clear count, pointers and head; after that edge out_valid=0, EXTout=0, op_err=0, count=0, in_ready=1.
REQ-029 SHALL give reset priority over flush, push and pop; reset asserted mid-stream discards all entries.
REQ-030 SHALL not require buffer data storage reset beyond the head output gating of REQ-021.

Verification
REQ-031 SHALL cover modes: imm=16'h8001, EXTop 0..6 -> FFFF8001, 00008001, 80010000, 00000001, 00000001, FFFF8001, 00008001; EXTop 7 -> 00008001 with op_err=1.
REQ-032 SHALL cover byte sign: imm=16'h0080, EXTop 3 -> FFFFFF80; EXTop 4 -> 00000080.
REQ-033 SHALL cover fill/backpressure: out_ready=0, push 3 items (DEPTH=2) -> first two accepted, in_ready=0 at count=2, third held; out_ready=1 -> outputs in order, third accepted same cycle as first pop.
REQ-034 SHALL cover push+pop at count=2 for 8 cycles -> count stays 2, results in order, pointer wrap correct.
REQ-035 SHALL cover flush with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, pushed item absent.
REQ-036 SHALL cover reset=0 with count=1 and in_valid=1 -> next cycle count=0, EXTout=0, in_ready=1; then IN_W=16, OUT_W=64 instance: imm=16'hFFFF, EXTop 2 -> 64'hFFFF000000000000.
